// File: rtl/cruise_pkg.sv
// Shared types and constants for the cruise-control command sequencer.
// The same set-speed limits are used by the cruise-control datapath.
package cruise_pkg;

  typedef enum logic [1:0] {IDLE, STEP, SETTLE, RESP} state_t;

  localparam int unsigned CMD_W = 6;
  typedef logic [CMD_W-1:0] cmd_t;

  // Bit position doubles as priority: the highest set bit wins.
  localparam int unsigned CMD_ACCEL  = 0;
  localparam int unsigned CMD_COAST  = 1;
  localparam int unsigned CMD_RESUME = 2;
  localparam int unsigned CMD_SET    = 3;
  localparam int unsigned CMD_CANCEL = 4;
  localparam int unsigned CMD_BRAKE  = 5;

  localparam cmd_t OH_ACCEL = cmd_t'(1) << CMD_ACCEL;
  localparam cmd_t OH_COAST = cmd_t'(1) << CMD_COAST;

  localparam int unsigned DEF_MIN_SET_SPEED = 46;
  localparam int unsigned DEF_MAX_SET_SPEED = 160;

  // Smear the highest request bit downwards, then keep only its top edge.
  function automatic cmd_t pick_winner(input cmd_t req);
    cmd_t m;
    m = req;
    for (int unsigned s = 1; s < CMD_W; s = s << 1)
      m = m | (m >> s);
    return m & ~(m >> 1);
  endfunction

endpackage

// File: rtl/cruise_drv_edge.sv
// Driver switch front end: registers the switch levels, edge-detects the
// momentary switches, keeps accel/coast as levels and picks one winner.
module cruise_drv_edge
  import cruise_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             drv_set,
  input  logic             drv_cancel,
  input  logic             drv_resume,
  input  logic             drv_brake,
  input  logic             drv_accel,
  input  logic             drv_coast,
  output logic [CMD_W-1:0] cmd,
  output logic             active
);

  cmd_t lvl;
  cmd_t lvl_q;
  cmd_t req;

  always_comb begin
    lvl             = '0;
    lvl[CMD_ACCEL]  = drv_accel;
    lvl[CMD_COAST]  = drv_coast;
    lvl[CMD_RESUME] = drv_resume;
    lvl[CMD_SET]    = drv_set;
    lvl[CMD_CANCEL] = drv_cancel;
    lvl[CMD_BRAKE]  = drv_brake;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) lvl_q <= '0;
    else       lvl_q <= lvl;
  end

  // Momentary switches fire on the rising edge; accel/coast repeat while held.
  always_comb begin
    req            = lvl & ~lvl_q;
    req[CMD_ACCEL] = lvl[CMD_ACCEL];
    req[CMD_COAST] = lvl[CMD_COAST];
  end

  assign cmd    = pick_winner(req);
  assign active = |req;

endmodule

// File: rtl/cruise_cmd_sequencer.sv
// Merges driver switches and ACC target requests into one registered,
// one-hot command stream for the cruise-control datapath.
module cruise_cmd_sequencer
  import cruise_pkg::*;
#(
  parameter int unsigned SPEED_W       = 8,
  parameter int unsigned MIN_SET_SPEED = DEF_MIN_SET_SPEED,
  parameter int unsigned MAX_SET_SPEED = DEF_MAX_SET_SPEED,
  parameter int unsigned STEP_TIMEOUT  = 200
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               drv_set,
  input  logic               drv_cancel,
  input  logic               drv_resume,
  input  logic               drv_brake,
  input  logic               drv_accel,
  input  logic               drv_coast,
  input  logic               acc_req,
  input  logic [SPEED_W-1:0] acc_target,
  input  logic [SPEED_W-1:0] cruise_speed,
  input  logic               cruise_status,
  output logic               cc_set,
  output logic               cc_cancel,
  output logic               cc_resume,
  output logic               cc_brake,
  output logic               cc_accel,
  output logic               cc_coast,
  output logic               acc_ack,
  output logic               acc_nak,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(STEP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(STEP_TIMEOUT);
  localparam logic [SPEED_W-1:0] MIN_S   = SPEED_W'(MIN_SET_SPEED);
  localparam logic [SPEED_W-1:0] MAX_S   = SPEED_W'(MAX_SET_SPEED);

  state_t             state;
  cmd_t               drv_cmd;
  cmd_t               cc_q;
  logic               drv_active;
  logic [SPEED_W-1:0] target_q;
  logic [CNT_W-1:0]   step_cnt;

  cruise_drv_edge u_drv_edge (
    .clock      (clock),
    .reset      (reset),
    .drv_set    (drv_set),
    .drv_cancel (drv_cancel),
    .drv_resume (drv_resume),
    .drv_brake  (drv_brake),
    .drv_accel  (drv_accel),
    .drv_coast  (drv_coast),
    .cmd        (drv_cmd),
    .active     (drv_active)
  );

  // The driver winner is the default command every cycle; ACC steps only
  // override it when the driver is idle, which keeps cc_* one-hot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      target_q <= '0;
      step_cnt <= '0;
      cc_q     <= '0;
      acc_ack  <= 1'b0;
      acc_nak  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      cc_q    <= drv_cmd;
      acc_ack <= 1'b0;
      acc_nak <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc_req && !drv_active) begin
            target_q <= acc_target;
            if (!cruise_status || acc_target < MIN_S || acc_target > MAX_S) begin
              state   <= RESP;
              acc_nak <= 1'b1;
            end else begin
              state    <= STEP;
              step_cnt <= '0;
              busy     <= 1'b1;
            end
          end
        end
        STEP: begin
          if (!acc_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (drv_active || !cruise_status) begin
            state   <= RESP;
            acc_nak <= 1'b1;
            busy    <= 1'b0;
          end else if (cruise_speed == target_q) begin
            state   <= RESP;
            acc_ack <= 1'b1;
            busy    <= 1'b0;
          end else if (step_cnt == CNT_MAX) begin
            state   <= RESP;
            acc_nak <= 1'b1;
            busy    <= 1'b0;
          end else begin
            cc_q     <= (cruise_speed < target_q) ? OH_ACCEL : OH_COAST;
            step_cnt <= step_cnt + 1'b1;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (!acc_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (drv_active || !cruise_status) begin
            state   <= RESP;
            acc_nak <= 1'b1;
            busy    <= 1'b0;
          end else begin
            state <= STEP;
          end
        end
        RESP: begin
          busy <= 1'b0;
          if (!acc_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cc_accel  = cc_q[CMD_ACCEL];
  assign cc_coast  = cc_q[CMD_COAST];
  assign cc_resume = cc_q[CMD_RESUME];
  assign cc_set    = cc_q[CMD_SET];
  assign cc_cancel = cc_q[CMD_CANCEL];
  assign cc_brake  = cc_q[CMD_BRAKE];

endmodule

// File: tb/tb_cruise_cmd_sequencer.sv
// Directed bench for cruise_cmd_sequencer with a simple cruise-speed model
// that follows cc_accel/cc_coast one cycle after they are issued.
module tb_cruise_cmd_sequencer;

  logic       clock;
  logic       reset;
  logic       drv_set, drv_cancel, drv_resume, drv_brake, drv_accel, drv_coast;
  logic       acc_req;
  logic [7:0] acc_target;
  logic [7:0] cruise_speed;
  logic       cruise_status;
  logic       cc_set, cc_cancel, cc_resume, cc_brake, cc_accel, cc_coast;
  logic       acc_ack, acc_nak, busy;

  int tests;
  int errors;
  int acc_pulses;
  int coast_pulses;
  int onehot_err;
  logic model_on;

  cruise_cmd_sequencer #(
    .SPEED_W      (8),
    .STEP_TIMEOUT (200)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .drv_set       (drv_set),
    .drv_cancel    (drv_cancel),
    .drv_resume    (drv_resume),
    .drv_brake     (drv_brake),
    .drv_accel     (drv_accel),
    .drv_coast     (drv_coast),
    .acc_req       (acc_req),
    .acc_target    (acc_target),
    .cruise_speed  (cruise_speed),
    .cruise_status (cruise_status),
    .cc_set        (cc_set),
    .cc_cancel     (cc_cancel),
    .cc_resume     (cc_resume),
    .cc_brake      (cc_brake),
    .cc_accel      (cc_accel),
    .cc_coast      (cc_coast),
    .acc_ack       (acc_ack),
    .acc_nak       (acc_nak),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [5:0] cmd_vec();
    return {cc_brake, cc_cancel, cc_set, cc_resume, cc_coast, cc_accel};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; the speed model applies the command that was visible before the edge.
  task automatic tick();
    logic pre_acc, pre_coast;
    pre_acc   = cc_accel;
    pre_coast = cc_coast;
    @(posedge clock);
    #1;
    if (model_on) begin
      if (pre_acc)   cruise_speed = cruise_speed + 8'd1;
      if (pre_coast) cruise_speed = cruise_speed - 8'd1;
    end
    if (cc_accel) acc_pulses++;
    if (cc_coast) coast_pulses++;
    if ($countones(cmd_vec()) > 1) onehot_err++;
  endtask

  task automatic run_acc(input logic [7:0] tgt, input logic [7:0] spd, input int bound,
                         output int t_resp, output logic got_ack, output logic got_nak);
    int n;
    acc_pulses   = 0;
    coast_pulses = 0;
    cruise_speed = spd;
    acc_target   = tgt;
    acc_req      = 1'b1;
    n = 0;
    while (!(acc_ack || acc_nak) && n < bound) begin
      tick();
      n++;
    end
    t_resp  = n;
    got_ack = acc_ack;
    got_nak = acc_nak;
  endtask

  int   r_tgt   [8] = '{55, 57, 30, 46, 45, 160, 161, 60};
  int   r_spd   [8] = '{50, 60, 50, 46, 50, 160, 150, 50};
  int   r_sts   [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
  int   r_t     [8] = '{12, 8, 1, 2, 1, 2, 1, 1};
  int   r_ack   [8] = '{1, 1, 0, 1, 0, 1, 0, 0};
  int   r_accp  [8] = '{5, 0, 0, 0, 0, 0, 0, 0};
  int   r_coastp[8] = '{0, 3, 0, 0, 0, 0, 0, 0};

  initial begin
    int   t;
    logic a, k, q;
    tests = 0; errors = 0; acc_pulses = 0; coast_pulses = 0; onehot_err = 0;
    model_on = 1'b0;
    reset = 1'b1;
    {drv_set, drv_cancel, drv_resume, drv_brake, drv_accel, drv_coast} = '1;
    acc_req = 1'b0; acc_target = '0; cruise_speed = '0; cruise_status = 1'b0;

    // Reset with every driver switch active.
    repeat (3) tick();
    chk("reset_outputs", {cmd_vec(), acc_ack, acc_nak, busy}, 0);
    reset = 1'b0;
    tick();
    chk("release_brake_wins", cmd_vec(), 6'b100000);
    tick();
    chk("held_coast_over_accel", cmd_vec(), 6'b000010);
    {drv_set, drv_cancel, drv_resume, drv_brake, drv_accel, drv_coast} = '0;
    tick();
    chk("driver_idle", cmd_vec(), 0);
    tick();

    // ACC requests: stepping, direct ack, range and status rejects.
    model_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cruise_status = r_sts[i][0];
      run_acc(8'(r_tgt[i]), 8'(r_spd[i]), 100, t, k, a);
      chk($sformatf("row%0d_resp_cycle", i), t, r_t[i]);
      chk($sformatf("row%0d_ack", i), k, r_ack[i]);
      chk($sformatf("row%0d_nak", i), a, r_ack[i] == 0);
      chk($sformatf("row%0d_accel_pulses", i), acc_pulses, r_accp[i]);
      chk($sformatf("row%0d_coast_pulses", i), coast_pulses, r_coastp[i]);
      chk($sformatf("row%0d_final_speed", i), cruise_speed,
          (r_ack[i] != 0) ? r_tgt[i] : r_spd[i]);
      q = 1'b0;
      repeat (4) begin
        tick();
        q = q | acc_ack | acc_nak | busy | (|cmd_vec());
      end
      chk($sformatf("row%0d_rtz_quiet", i), q, 0);
      acc_req = 1'b0;
      repeat (2) tick();
    end

    // Brake during stepping 50->70 aborts after the third pulse.
    cruise_status = 1'b1;
    acc_pulses = 0;
    cruise_speed = 8'd50;
    acc_target = 8'd70;
    acc_req = 1'b1;
    t = 0;
    while (acc_pulses < 3 && t < 50) begin
      tick();
      t++;
    end
    chk("brake_third_pulse_seen", acc_pulses, 3);
    drv_brake = 1'b1;
    tick();
    chk("brake_cmd", cmd_vec(), 6'b100000);
    chk("brake_nak", acc_nak, 1);
    chk("brake_no_ack", acc_ack, 0);
    chk("brake_busy_low", busy, 0);
    repeat (4) tick();
    chk("brake_no_more_accel", acc_pulses, 3);
    drv_brake = 1'b0;
    acc_req = 1'b0;
    repeat (2) tick();

    // Simultaneous set/resume edges with accel held.
    drv_set = 1'b1; drv_resume = 1'b1; drv_accel = 1'b1;
    tick();
    chk("set_wins", cmd_vec(), 6'b001000);
    tick();
    chk("accel_held_1", cmd_vec(), 6'b000001);
    tick();
    chk("accel_held_2", cmd_vec(), 6'b000001);
    drv_set = 1'b0; drv_resume = 1'b0; drv_accel = 1'b0;
    tick();
    chk("driver_released", cmd_vec(), 0);
    tick();

    // Request dropped mid-sequence: no response at all.
    cruise_speed = 8'd50;
    acc_target = 8'd60;
    acc_req = 1'b1;
    tick();
    tick();
    chk("drop_first_pulse", cc_accel, 1);
    acc_req = 1'b0;
    q = 1'b0;
    repeat (6) begin
      tick();
      q = q | acc_ack | acc_nak | busy | cc_accel | cc_coast;
    end
    chk("drop_no_response", q, 0);

    // Stuck datapath: timeout after exactly 200 pulses.
    model_on = 1'b0;
    run_acc(8'd100, 8'd50, 1000, t, k, a);
    chk("timeout_resp_cycle", t, 402);
    chk("timeout_nak", a, 1);
    chk("timeout_no_ack", k, 0);
    chk("timeout_pulses", acc_pulses, 200);
    acc_req = 1'b0;
    repeat (2) tick();

    // Async reset in the middle of a sequence.
    cruise_speed = 8'd50;
    acc_target = 8'd100;
    acc_req = 1'b1;
    repeat (20) tick();
    chk("midseq_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {cmd_vec(), acc_ack, acc_nak, busy}, 0);
    acc_req = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    q = 1'b0;
    repeat (10) begin
      tick();
      q = q | acc_ack | acc_nak | busy;
    end
    chk("after_reset_no_response", q, 0);

    chk("cmd_onehot", onehot_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/cruise_cmd_sequencer.md
Name: cruise_cmd_sequencer

Overview:
Command sequencer placed in front of the cruise-control datapath. It merges two requesters into one legal command stream on the cruise-control inputs:
- Driver stalk/pedal switches: level inputs.
- Adaptive-cruise (ACC) unit: req/ack handshake carrying a target cruise speed. The block steps cruise_speed to the target with accel/coast pulses.

Driver activity always pre-empts ACC. At most one command is issued per cycle.

Parameters:
SPEED_W, 8, width of speed/target buses
MIN_SET_SPEED, 46, lowest legal ACC target (mph)
MAX_SET_SPEED, 160, highest legal ACC target (mph)
STEP_TIMEOUT, 200, max accel/coast pulses per ACC request before abort

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
drv_set, drv_cancel, drv_resume, drv_brake  in  1 each  driver switch levels
drv_accel, drv_coast  in  1 each  driver switch levels (hold-to-repeat)
acc_req  in  1  ACC request; held high until acc_ack/acc_nak seen, then dropped
acc_target  in  SPEED_W  requested cruise speed; stable while acc_req high
cruise_speed  in  SPEED_W  current cruise speed from cruise control
cruise_status  in  1  cruise engaged flag from cruise control
cc_set, cc_cancel, cc_resume, cc_brake, cc_accel, cc_coast  out  1 each  commands to cruise control
acc_ack  out  1  one-cycle pulse: target reached
acc_nak  out  1  one-cycle pulse: request rejected or aborted
busy  out  1  ACC sequence in progress

Behaviour:
Reset and output timing:
- On reset (async): all outputs 0, state IDLE, edge-detect registers 0, step counter 0.
- All outputs are registered. A command appears 1 cycle after the input that caused it.

Driver path:
- set/cancel/resume/brake are rising-edge detected and produce a single-cycle cc_* pulse.
- accel/coast are levels: cc_accel/cc_coast are asserted every cycle the switch is held.
- Priority among simultaneous driver events: brake > cancel > set > resume > coast > accel. Only the winner is issued; losing edges are dropped, not queued.
- The cc_* outputs are one-hot or all-zero in every cycle.

States: IDLE, STEP, SETTLE, RESP.
- IDLE, acc_req=1 and no driver activity this cycle:
  - Capture acc_target into target_q.
  - If cruise_status=0 or target_q is outside [MIN_SET_SPEED, MAX_SET_SPEED], go to RESP with nak.
  - Otherwise go to STEP, clear step_cnt, set busy=1.
- STEP:
  - cruise_speed < target_q: issue cc_accel for 1 cycle, step_cnt+1, go to SETTLE.
  - cruise_speed > target_q: issue cc_coast for 1 cycle, step_cnt+1, go to SETTLE.
  - Equal: go to RESP with ack.
- SETTLE: issue no command for 1 cycle so the datapath update becomes visible, then return to STEP. The step rate is therefore 1 mph per 2 cycles.
- Abort to RESP with nak on any of:
  - any driver activity (edge or held level) in STEP or SETTLE; the driver command is still issued that cycle;
  - cruise_status=0 in STEP or SETTLE;
  - step_cnt = STEP_TIMEOUT.
- RESP:
  - acc_ack or acc_nak pulses exactly 1 cycle on entry; busy=0.
  - Stay in RESP until acc_req=0, then go to IDLE. This is a return-to-zero handshake: no new acceptance while acc_req remains high.
- acc_ack and acc_nak are never both high. Neither is ever asserted without a preceding accepted acc_req.

Boundary and corner cases:
- acc_target equal to cruise_speed at accept: ack after 1 STEP cycle, zero pulses issued.
- acc_req dropped mid-sequence (protocol violation): finish the current SETTLE, then go to IDLE with no ack or nak.
- Reset mid-sequence: everything returns to IDLE with no response. ACC must re-request.
- Comparisons are unsigned SPEED_W-bit.
- step_cnt saturates at STEP_TIMEOUT.

Decomposition:
- Shared package cruise_pkg holds:
  - state enum (IDLE/STEP/SETTLE/RESP);
  - command one-hot encoding and priority order constants;
  - MIN_SET_SPEED/MAX_SET_SPEED defaults, shared with the cruise control.
- One natural sub-module: cruise_drv_edge. It registers the six driver levels, produces rising-edge pulses and held-level flags, and performs priority resolution to a one-hot winner.
- The FSM and handshake stay in the top module.

Test Plan:
1. Reset with all inputs active, then release -> all outputs 0 during reset; the first cycle after release issues only the winning driver command per priority (cc_brake if drv_brake=1).
2. cruise_status=1, cruise_speed=50, acc_req with target=55 (model increments on cc_accel) -> 5 cc_accel pulses, each 2 cycles apart, then acc_ack 1 cycle; busy low afterward; no further command until acc_req drops and re-rises.
3. cruise_speed=60, target=57 -> 3 cc_coast pulses, then acc_ack; a target of 30 instead -> acc_nak 1 cycle after accept, no cc_* issued.
4. ACC stepping 50->70, drv_brake rises at the 3rd pulse -> cc_brake next cycle, acc_nak same cycle, no further cc_accel, busy=0.
5. Simultaneous drv_set and drv_resume rising edges plus held drv_accel -> cc_set for 1 cycle only, then cc_accel each following cycle while drv_accel is held; cc_* stays one-hot throughout.
6. Model that ignores cc_accel, target=100 from 50 -> exactly STEP_TIMEOUT (200) pulses, then acc_nak; async reset asserted mid-sequence in a rerun -> outputs 0 immediately, no ack or nak.
